// File: rtl/vcd_pkg.sv
// Shared types and constants for the value-change replay block.
package vcd_pkg;

    localparam int unsigned DEF_NSIG = 6;
    localparam int unsigned DEF_TW   = 16;
    localparam int unsigned NOW_W    = 32;

    // Index field width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nsig);
        return (nsig > 1) ? $clog2(nsig) : 1;
    endfunction

    localparam int unsigned DEF_IW = idx_width(DEF_NSIG);

    typedef struct packed {
        logic [DEF_TW-1:0] dt;
        logic [DEF_IW-1:0] idx;
        logic              val;
        logic              last;
    } vcd_rec_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } vcd_state_e;

endpackage

// File: rtl/vcd_rec_hold.sv
// One-entry record holding register; a load on the releasing edge keeps it full.
module vcd_rec_hold
    import vcd_pkg::*;
#(
    parameter type rec_t = vcd_rec_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_release,
    input  rec_t i_rec,
    output rec_t o_rec,
    output logic o_full
);

    rec_t r_rec;
    logic r_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec  <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_rec  <= i_rec;
            r_full <= 1'b1;
        end else if (i_release) begin
            r_full <= 1'b0;
        end
    end

    assign o_rec  = r_rec;
    assign o_full = r_full;

endmodule

// File: rtl/vcd_player.sv
// Replays (delta-time, index, value) records onto a bank of output bits,
// applying each record dt+1 enabled cycles after it is accepted.
module vcd_player
    import vcd_pkg::*;
#(
    parameter  int unsigned NSIG = DEF_NSIG,
    parameter  int unsigned TW   = DEF_TW,
    localparam int unsigned IW   = idx_width(NSIG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [TW-1:0]    i_in_dt,
    input  logic [IW-1:0]    i_in_idx,
    input  logic             i_in_val,
    input  logic             i_in_last,
    output logic [NSIG-1:0]  o_dout,
    output logic [NOW_W-1:0] o_now,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    typedef struct packed {
        logic [TW-1:0] dt;
        logic [IW-1:0] idx;
        logic          val;
        logic          last;
    } rec_t;

    rec_t             w_in_rec;
    rec_t             w_hold;
    logic             w_full;
    logic             w_hit;
    logic             w_apply;
    logic             w_accept;
    logic             w_idx_ok;

    vcd_state_e       r_state;
    logic [TW-1:0]    r_cnt;
    logic [NOW_W-1:0] r_now;
    logic [NSIG-1:0]  r_dout;
    logic             r_done;
    logic             r_err;

    assign w_in_rec = '{dt: i_in_dt, idx: i_in_idx, val: i_in_val, last: i_in_last};

    assign w_hit    = (r_cnt == w_hold.dt);
    assign w_apply  = (r_state == StWait) && i_en && w_hit;
    assign w_idx_ok = (32'(w_hold.idx) < NSIG);

    // Ready while applying lets the next record load on the same edge (no bubble).
    assign o_in_ready = !r_done && (!w_full || (i_en && w_hit && !w_hold.last));
    assign w_accept   = i_in_valid && o_in_ready;

    vcd_rec_hold #(
        .rec_t (rec_t)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept),
        .i_release (w_apply),
        .i_rec     (w_in_rec),
        .o_rec     (w_hold),
        .o_full    (w_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_now   <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (i_en && !r_done) begin
                r_now <= r_now + 1'b1;
            end

            if (w_accept) begin
                r_cnt <= '0;
            end else if ((r_state == StWait) && i_en && !w_hit) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_apply) begin
                if (w_idx_ok) begin
                    r_dout[w_hold.idx] <= w_hold.val;
                end else begin
                    r_err <= 1'b1;
                end
            end

            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (w_apply) begin
                        if (w_hold.last) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else if (!w_accept) begin
                            r_state <= StIdle;
                        end
                    end
                end
                StDone: begin
                    r_state <= StDone;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_dout = r_dout;
    assign o_now  = r_now;
    assign o_busy = w_full;
    assign o_done = r_done;
    assign o_err  = r_err;

endmodule

// File: tb/tb_vcd_player.sv
// Directed bench for vcd_player with hand-computed expectations and a small dout scoreboard.
module tb_vcd_player;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_dt;
    logic [2:0]  in_idx;
    logic        in_val;
    logic        in_last;
    logic [5:0]  dout;
    logic [31:0] now;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    vcd_player dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (en),
        .i_in_valid (in_valid),
        .o_in_ready (in_ready),
        .i_in_dt    (in_dt),
        .i_in_idx   (in_idx),
        .i_in_val   (in_val),
        .i_in_last  (in_last),
        .o_dout     (dout),
        .o_now      (now),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [15:0] dt, input logic [2:0] idx, input logic val,
                           input logic last);
        in_valid = 1'b1;
        in_dt    = dt;
        in_idx   = idx;
        in_val   = val;
        in_last  = last;
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    logic [5:0] model;
    logic       pend;
    logic [2:0] p_idx;
    logic       p_val;
    int         gap;

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        in_valid = 1'b0;
        in_dt    = '0;
        in_idx   = '0;
        in_val   = 1'b0;
        in_last  = 1'b0;

        // Reset values and a pending record dropped by a mid-wait reset
        tick();
        tick();
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_now", now, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(in_ready), 32'h1);
        en = 1'b1;
        present(16'd5, 3'd1, 1'b1, 1'b0);
        tick();
        check("pend_busy", 32'(busy), 32'h1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_dout", 32'(dout), 32'h0);
        check("midrst_now", now, 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("postrst_ready", 32'(in_ready), 32'h1);
        repeat (8) tick();
        check("dropped_dout", 32'(dout), 32'h0);
        check("dropped_busy", 32'(busy), 32'h0);

        // Basic three-record stream; first record accepted with en=0 so now counts from k
        do_reset();
        present(16'd3, 3'd0, 1'b1, 1'b0);
        check("s_ready0", 32'(in_ready), 32'h1);
        tick();
        check("s_busy_k", 32'(busy), 32'h1);
        check("s_now_k", now, 32'h0);
        in_valid = 1'b0;
        en       = 1'b1;
        repeat (3) tick();
        check("s_dout_k3", 32'(dout), 32'h00);
        present(16'd0, 3'd2, 1'b1, 1'b0);
        check("s_ready_k3", 32'(in_ready), 32'h1);
        tick();
        check("s_dout_k4", 32'(dout), 32'h01);
        check("s_busy_k4", 32'(busy), 32'h1);
        present(16'd1, 3'd0, 1'b0, 1'b1);
        check("s_ready_k4", 32'(in_ready), 32'h1);
        tick();
        check("s_dout_k5", 32'(dout), 32'h05);
        in_valid = 1'b0;
        tick();
        check("s_dout_k6", 32'(dout), 32'h05);
        check("s_done_k6", 32'(done), 32'h0);
        tick();
        check("s_dout_k7", 32'(dout), 32'h04);
        check("s_done_k7", 32'(done), 32'h1);
        check("s_now_k7", now, 32'd7);
        check("s_busy_k7", 32'(busy), 32'h0);
        present(16'd0, 3'd1, 1'b1, 1'b0);
        check("s_ready_done", 32'(in_ready), 32'h0);
        repeat (3) tick();
        check("s_now_hold", now, 32'd7);
        check("s_dout_hold", 32'(dout), 32'h04);
        check("s_done_hold", 32'(done), 32'h1);
        in_valid = 1'b0;

        // Enable gap of 3 cycles during a dt=4 wait
        do_reset();
        en = 1'b1;
        present(16'd4, 3'd3, 1'b1, 1'b0);
        tick();
        check("g_now_k", now, 32'd1);
        in_valid = 1'b0;
        tick();
        tick();
        en = 1'b0;
        repeat (3) tick();
        check("g_busy_k5", 32'(busy), 32'h1);
        check("g_dout_k5", 32'(dout), 32'h00);
        en = 1'b1;
        tick();
        tick();
        check("g_dout_k7", 32'(dout), 32'h00);
        tick();
        check("g_dout_k8", 32'(dout), 32'h08);
        check("g_now_k8", now, 32'd6);
        check("g_busy_k8", 32'(busy), 32'h0);

        // Out-of-range index sets err and leaves dout alone
        present(16'd0, 3'd7, 1'b1, 1'b0);
        tick();
        check("b_err_acc", 32'(err), 32'h0);
        in_valid = 1'b0;
        tick();
        check("b_err_apply", 32'(err), 32'h1);
        check("b_dout_apply", 32'(dout), 32'h08);
        present(16'd1, 3'd5, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        check("b_dout_wait", 32'(dout), 32'h08);
        tick();
        check("b_dout_next", 32'(dout), 32'h28);
        check("b_err_sticky", 32'(err), 32'h1);

        // Source backpressure: dt=0 records with random valid gaps, scoreboarded
        model = 6'h28;
        pend  = 1'b0;
        p_idx = '0;
        p_val = 1'b0;
        for (int i = 0; i < 16; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                tick();
                if (pend) begin
                    model[p_idx] = p_val;
                    pend = 1'b0;
                end
                check("bp_dout_gap", 32'(dout), 32'(model));
                check("bp_busy_gap", 32'(busy), 32'h0);
            end
            present(16'd0, 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'b0);
            check("bp_ready", 32'(in_ready), 32'h1);
            tick();
            if (pend) begin
                model[p_idx] = p_val;
            end
            pend  = 1'b1;
            p_idx = in_idx;
            p_val = in_val;
            check("bp_dout_acc", 32'(dout), 32'(model));
            check("bp_busy_acc", 32'(busy), 32'h1);
        end
        in_valid = 1'b0;
        tick();
        model[p_idx] = p_val;
        check("bp_dout_end", 32'(dout), 32'(model));
        check("bp_busy_end", 32'(busy), 32'h0);

        // now wraps modulo 2^32
        en = 1'b0;
        force dut.r_now = 32'hFFFF_FFFE;
        #1;
        release dut.r_now;
        #1;
        check("w_now_forced", now, 32'hFFFF_FFFE);
        en = 1'b1;
        repeat (3) tick();
        check("w_now_wrap", now, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vcd_player.md
# vcd_player

Replays a stream of value-change records onto a bank of single-bit output wires, cycle-accurately. It is the consumer-side counterpart of our VCD dump flow: where the dump flow records per-signal changes with timestamps, this block takes (delta-time, signal index, value) records and re-drives the signals at the recorded times. It sits between a record source (ROM, DMA or host FIFO) and the DUT inputs in hardware regression benches.

## Interface
- NSIG, 6: number of replayed output bits.
- TW, 16: width of the delta-time field.
- IW, $clog2(NSIG) (min 1): width of the index field; derived, not overridden.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; 0 freezes replay time.
- in_valid  in  1  record present.
- in_ready  out  1  block accepts the record this cycle.
- in_dt  in  TW  wait, in cycles, before this record applies.
- in_idx  in  IW  target bit of dout.
- in_val  in  1  new value for dout[in_idx].
- in_last  in  1  final record of the dump.
- dout  out  NSIG  replayed signals.
- now  out  32  replay time: enabled cycles since reset.
- busy  out  1  a record is held and pending.
- done  out  1  sticky: last record applied.
- err  out  1  sticky: out-of-range index seen.

## Operation
- Record transfers on a rising edge when in_valid && in_ready.
- Holds one record at a time. A 1-entry hold register has fields dt, idx, val, last, and a full flag.
- The wait counter cnt (TW bits) clears to 0 when a record loads.
- States:
  - IDLE: hold empty, done=0.
  - WAIT: hold full.
  - DONE: terminal.
- IDLE -> WAIT on accept.
- WAIT, on an edge with en=1:
  - if cnt == dt, apply the record.
  - otherwise cnt increments.
- Apply means:
  - if idx < NSIG, dout[idx] <= val; otherwise dout is unchanged and err <= 1.
  - the hold register is released.
  - if last=1, go to DONE. Otherwise go to WAIT if a new record is accepted on the same edge, else IDLE.
- in_ready = !done && (!full || (en && cnt == dt && !last)). This is combinational, so back-to-back records stream with no bubble.
- en=0: cnt and now freeze and no apply occurs. A record may still be accepted in IDLE.
- DONE: in_ready=0. dout, now and err hold. Leaving DONE requires reset.
- now increments on every edge with en=1 && !done and wraps modulo 2^32.
- Only the addressed bit of dout changes; all other bits hold.

## Timing
- Reset (async assert, value held while rst_n=0):
  - dout=0, now=0, busy=0, done=0, err=0, cnt=0, hold empty.
  - in_ready=1 once rst_n=1.
- Record accepted at edge k, with en=1 continuously, applies at edge k+1+dt. The dout change is visible after that edge.
- Consecutive streamed records: spacing between applications is dt+1 cycles. The source encodes a VCD delta D as dt=D-1, with D ≥ 1.
- dt=0 is the minimum: the record applies on the first edge after acceptance.
- en low for m cycles during WAIT delays the application by exactly m cycles.
- busy equals the full flag and deasserts on the applying edge unless a new record loads on that edge.
- done rises on the edge that applies the last record.
- Reset asserted mid-WAIT drops the pending record silently. No partial apply.

## Structure
- Package vcd_pkg holds:
  - typedef vcd_rec_t: struct {dt, idx, val, last}, parameterised by TW and IW.
  - state enum {IDLE, WAIT, DONE}.
  - constant NOW_W = 32.
- Natural sub-module: vcd_rec_hold, the 1-entry hold register with full flag and load/release ports.
- The top level holds the FSM, cnt, now, and the dout/err registers.

## Test plan
- Reset: rst_n low mid-stream, with in_valid=1 and dt=5 pending. Required:
  - dout=0, now=0, busy=0, done=0 immediately.
  - after release, in_ready=1 and the pending record never applies.
- Basic stream, en=1, three records back-to-back:
  - inputs: (dt=3, idx=0, val=1), (dt=0, idx=2, val=1), (dt=1, idx=0, val=0, last).
  - dout[0]=1 after edge k+4; dout[2]=1 at k+5; dout[0]=0 at k+7.
  - done=1 at k+7; now stops at 7; in_ready=0 afterwards.
- Enable gap: record dt=4 with en low for 3 cycles mid-wait. Required:
  - application 3 cycles later than without the gap.
  - now is 3 lower than elapsed cycles.
- Bad index, NSIG=6: record idx=7, val=1. Required:
  - err=1 at the apply edge and dout unchanged.
  - the next valid record still applies normally.
- Source backpressure: in_valid pulsed with random gaps, dt=0 records. Required:
  - every record applies exactly 1 cycle after its acceptance.
  - no record is lost or duplicated; dout matches a scoreboard bit-for-bit.
- now wrap: force now to 0xFFFFFFFE, run 3 enabled cycles -> now=1.
